rename_alias_table: RTL and testbench
=====================================

# rename_alias_table

Parametrised register alias table for the out-of-order LC-3b core. It records, per architectural register, whether a result is pending and which ROB tag will produce it. It supports two in-order allocations per cycle, a CDB-driven clear, a global flush, and branch checkpoints with single-cycle restore. It sits between decode/dispatch and the reservation stations and replaces the 1-bit two-write status file.

## Interface
Parameters:
- `TAG_WIDTH`, default 4: ROB tag width.
- `ADDR_WIDTH`, default 3: register index width. `NUM_REGS = 2**ADDR_WIDTH`.
- `NUM_CKPT`, default 2: number of checkpoint slots, at least 1. `CKPT_W = $clog2(NUM_CKPT)`, minimum 1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `flush`, in, 1: clear all busy bits and all checkpoints.
- `rd_a_addr`, `rd_b_addr`, in, ADDR_WIDTH: source lookups.
- `rd_a_busy`, `rd_b_busy`, out, 1: entry pending.
- `rd_a_tag`, `rd_b_tag`, out, TAG_WIDTH: stored tag.
- `alloc_a`, `alloc_b`, in, 1: dispatch allocations. Slot a is older than slot b.
- `alloc_a_addr`, `alloc_b_addr`, in, ADDR_WIDTH: destination registers.
- `alloc_a_tag`, `alloc_b_tag`, in, TAG_WIDTH: ROB tags.
- `cdb_valid`, in, 1; `cdb_addr`, in, ADDR_WIDTH; `cdb_tag`, in, TAG_WIDTH: result broadcast.
- `ckpt_save`, in, 1; `ckpt_save_id`, in, CKPT_W: snapshot request.
- `ckpt_restore`, in, 1; `ckpt_restore_id`, in, CKPT_W: mispredict recovery.
- `ckpt_valid`, out, NUM_CKPT: slot holds a live snapshot.
- `restore_err`, out, 1: registered pulse; a restore targeted an invalid slot.
- `busy_count`, out, ADDR_WIDTH+1: population count of busy bits.

## Operation
- **State**: `busy[NUM_REGS]` and `tag[NUM_REGS]`; one copy per checkpoint slot, each with a valid bit.
- **Reads**: combinational from current state. There is no bypass of same-cycle writes.
- **Per-entry update order, within one edge**:
  1. CDB clear: sets busy to 0 when `cdb_valid`, the entry is busy, and its stored tag equals `cdb_tag`.
  2. `alloc_a`.
  3. `alloc_b`.
  - Each later step overrides earlier ones. If both slots allocate the same address, b wins. An allocation beats a same-cycle CDB clear of that entry.
- **Checkpoint save**: slot `ckpt_save_id` captures the next-state table, including this cycle's clear and allocations. Its valid bit is set. Overwriting a valid slot is allowed.
- **Checkpoint CDB**: every valid checkpoint slot also applies the CDB clear rule each cycle.
- **Restore, valid slot**: the live table loads the slot's contents with the same-cycle CDB clear applied. Same-cycle allocations and save are ignored. The slot's valid bit clears.
- **Restore, invalid slot**: no state change; `restore_err` is 1 on the next cycle.
- **Priority**: `reset` > `flush` > `ckpt_restore` > (`ckpt_save`, alloc, CDB).
- **Flush**: busy and tag go to 0 and all `ckpt_valid` go to 0. Alloc, save and restore are ignored that cycle.
- **Tag width**: tag compare is full-width equality. Tag 0 is a legal tag, and busy alone qualifies the entry.

## Timing
- **Reset**: all busy 0, all tags 0, `ckpt_valid` 0, `restore_err` 0. `busy_count` reads 0.
- **Alloc latency**: an allocation becomes visible on `rd_*` one cycle after the edge that samples it.
- **CDB latency**: a clear becomes visible one cycle after the edge.
- **Outputs**: `busy_count` is combinational from current state. `restore_err` is registered and lasts one cycle per failed restore.
- **Reset mid-operation**: asynchronous assertion clears everything immediately. Inputs are ignored while `reset` is high.
- **Back-to-back**: save and restore of the same id are legal on consecutive cycles. Restore sees the snapshot taken on the previous edge.

## Configuration
- **`RAT_CKPT_EN` defined**: checkpoint storage and logic are compiled in, as described above.
- **`RAT_CKPT_EN` undefined**:
  - No checkpoint storage.
  - `ckpt_save` and `ckpt_restore` are ignored.
  - `ckpt_valid` ties to 0 and `restore_err` ties to 0.
  - All ports remain.

## Test plan
- **Alloc then read**: reset, then `alloc_a` r3 with tag 5 → next cycle `rd_a_addr`=3 gives busy=1, tag=5, and `busy_count`=1.
- **Dual alloc, same destination**: `alloc_a` r2 tag 4 and `alloc_b` r2 tag 7 in one cycle → r2 busy with tag 7; `busy_count`=1.
- **CDB tag match**: r1 holds tag 6. CDB r1 tag 3 → r1 stays busy. CDB r1 tag 6 → r1 not busy. CDB r1 tag 6 concurrent with `alloc_a` r1 tag 9 → r1 busy with tag 9.
- **Checkpoint restore**:
  - Sequence: alloc r4 tag 2, then save slot 0, then alloc r4 tag 8 plus r5 tag 9, then CDB r4 tag 2, then restore slot 0.
  - Required: r4 not busy, r5 not busy, `ckpt_valid[0]`=0.
- **Invalid restore and flush**:
  - Restore slot 1 with no save → state unchanged and `restore_err`=1 for one cycle.
  - Save slot 1 then flush → all busy 0 and `ckpt_valid`=0.
- **Asynchronous reset**: assert `reset` between edges with r0–r7 busy → outputs go to 0 without a clock edge. With `RAT_CKPT_EN` undefined, the checkpoint tests show `ckpt_valid`=0 and the table unchanged by restore.

Source files
------------

// File: rtl/rename_alias_table.sv
`default_nettype none
// ============================================================================
// Module   : rename_alias_table
// Purpose  : Register alias table (busy + ROB tag per register). Supports dual
//            in-order allocation, CDB clear and flush. Define RAT_CKPT_EN to
//            add branch checkpoints with single-cycle restore.
// Revision : 1.0
// ============================================================================
module rename_alias_table #(
    parameter int  TAG_WIDTH  = 4,
    parameter int  ADDR_WIDTH = 3,
    parameter int  NUM_CKPT   = 2,
    localparam int NUM_REGS   = 2**ADDR_WIDTH,
    localparam int CKPT_W     = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  rd_a_addr,
    input  logic [ADDR_WIDTH-1:0]  rd_b_addr,
    output logic                   rd_a_busy,
    output logic                   rd_b_busy,
    output logic [TAG_WIDTH-1:0]   rd_a_tag,
    output logic [TAG_WIDTH-1:0]   rd_b_tag,
    input  logic                   alloc_a,
    input  logic                   alloc_b,
    input  logic [ADDR_WIDTH-1:0]  alloc_a_addr,
    input  logic [ADDR_WIDTH-1:0]  alloc_b_addr,
    input  logic [TAG_WIDTH-1:0]   alloc_a_tag,
    input  logic [TAG_WIDTH-1:0]   alloc_b_tag,
    input  logic                   cdb_valid,
    input  logic [ADDR_WIDTH-1:0]  cdb_addr,
    input  logic [TAG_WIDTH-1:0]   cdb_tag,
    input  logic                   ckpt_save,
    input  logic [CKPT_W-1:0]      ckpt_save_id,
    input  logic                   ckpt_restore,
    input  logic [CKPT_W-1:0]      ckpt_restore_id,
    output logic [NUM_CKPT-1:0]    ckpt_valid,
    output logic                   restore_err,
    output logic [ADDR_WIDTH:0]    busy_count
);

    logic [NUM_REGS-1:0]  r_busy;
    logic [TAG_WIDTH-1:0] r_tag [NUM_REGS];
    logic [NUM_REGS-1:0]  w_nxt_busy;
    logic [TAG_WIDTH-1:0] w_nxt_tag [NUM_REGS];
    logic                 w_restore;
    logic                 w_rst_hit;
    logic [NUM_REGS-1:0]  w_rst_busy;
    logic [TAG_WIDTH-1:0] w_rst_tag [NUM_REGS];
    logic [ADDR_WIDTH:0]  w_count;

    // Next live table: CDB clear, then slot a, then slot b (later wins).
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_nxt_busy[i] = r_busy[i];
            w_nxt_tag[i]  = r_tag[i];
            if (cdb_valid && cdb_addr == ADDR_WIDTH'(i) && r_tag[i] == cdb_tag) begin
                w_nxt_busy[i] = 1'b0;
            end
            if (alloc_a && alloc_a_addr == ADDR_WIDTH'(i)) begin
                w_nxt_busy[i] = 1'b1;
                w_nxt_tag[i]  = alloc_a_tag;
            end
            if (alloc_b && alloc_b_addr == ADDR_WIDTH'(i)) begin
                w_nxt_busy[i] = 1'b1;
                w_nxt_tag[i]  = alloc_b_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_tag[i] <= '0;
        end else if (flush) begin
            r_busy <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_tag[i] <= '0;
        end else if (w_restore) begin
            if (w_rst_hit) begin
                r_busy <= w_rst_busy;
                for (int i = 0; i < NUM_REGS; i++) r_tag[i] <= w_rst_tag[i];
            end
        end else begin
            r_busy <= w_nxt_busy;
            for (int i = 0; i < NUM_REGS; i++) r_tag[i] <= w_nxt_tag[i];
        end
    end

    assign rd_a_busy = r_busy[rd_a_addr];
    assign rd_b_busy = r_busy[rd_b_addr];
    assign rd_a_tag  = r_tag[rd_a_addr];
    assign rd_b_tag  = r_tag[rd_b_addr];

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_count = w_count + {{ADDR_WIDTH{1'b0}}, r_busy[i]};
        end
    end
    assign busy_count = w_count;

`ifdef RAT_CKPT_EN
    logic [NUM_CKPT-1:0]  r_ck_valid;
    logic [NUM_REGS-1:0]  r_ck_busy [NUM_CKPT];
    logic [TAG_WIDTH-1:0] r_ck_tag  [NUM_CKPT][NUM_REGS];
    logic [NUM_REGS-1:0]  w_ck_clr  [NUM_CKPT];
    logic                 r_restore_err;

    // Snapshots track retiring results too, so a restore never revives a done entry.
    always_comb begin
        for (int k = 0; k < NUM_CKPT; k++) begin
            w_ck_clr[k] = r_ck_busy[k];
            for (int i = 0; i < NUM_REGS; i++) begin
                if (cdb_valid && cdb_addr == ADDR_WIDTH'(i) && r_ck_tag[k][i] == cdb_tag) begin
                    w_ck_clr[k][i] = 1'b0;
                end
            end
        end
    end

    // Select by compare loop so an out-of-range id simply reads as invalid.
    always_comb begin
        w_rst_hit  = 1'b0;
        w_rst_busy = '0;
        for (int i = 0; i < NUM_REGS; i++) w_rst_tag[i] = '0;
        for (int k = 0; k < NUM_CKPT; k++) begin
            if (ckpt_restore_id == CKPT_W'(k)) begin
                w_rst_hit  = r_ck_valid[k];
                w_rst_busy = w_ck_clr[k];
                for (int i = 0; i < NUM_REGS; i++) w_rst_tag[i] = r_ck_tag[k][i];
            end
        end
    end

    assign w_restore = ckpt_restore;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ck_valid    <= '0;
            r_restore_err <= 1'b0;
            for (int k = 0; k < NUM_CKPT; k++) begin
                r_ck_busy[k] <= '0;
                for (int i = 0; i < NUM_REGS; i++) r_ck_tag[k][i] <= '0;
            end
        end else if (flush) begin
            r_ck_valid    <= '0;
            r_restore_err <= 1'b0;
        end else if (ckpt_restore) begin
            r_restore_err <= ~w_rst_hit;
            if (w_rst_hit) begin
                for (int k = 0; k < NUM_CKPT; k++) begin
                    r_ck_busy[k] <= w_ck_clr[k];
                    if (ckpt_restore_id == CKPT_W'(k)) r_ck_valid[k] <= 1'b0;
                end
            end
        end else begin
            r_restore_err <= 1'b0;
            for (int k = 0; k < NUM_CKPT; k++) begin
                if (ckpt_save && ckpt_save_id == CKPT_W'(k)) begin
                    r_ck_valid[k] <= 1'b1;
                    r_ck_busy[k]  <= w_nxt_busy;
                    for (int i = 0; i < NUM_REGS; i++) r_ck_tag[k][i] <= w_nxt_tag[i];
                end else begin
                    r_ck_busy[k] <= w_ck_clr[k];
                end
            end
        end
    end

    assign ckpt_valid  = r_ck_valid;
    assign restore_err = r_restore_err;
`else
    logic w_unused_ckpt;

    assign w_restore  = 1'b0;
    assign w_rst_hit  = 1'b0;
    assign w_rst_busy = '0;
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) w_rst_tag[i] = '0;
    end

    assign ckpt_valid    = '0;
    assign restore_err   = 1'b0;
    assign w_unused_ckpt = ^{ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id};
`endif

endmodule
`default_nettype wire

// File: tb/tb_rename_alias_table.sv
`default_nettype none
// tb_rename_alias_table: directed stimulus, a behavioural alias-table model
// compared every cycle, and hand-computed literal checks.
module tb_rename_alias_table;

    localparam int TW = 4;
    localparam int AW = 3;
    localparam int NC = 2;
    localparam int NR = 8;
`ifdef RAT_CKPT_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush, alloc_a, alloc_b, cdb_valid, ckpt_save, ckpt_restore;
    logic [AW-1:0] rd_a_addr = '0, rd_b_addr = '0;
    logic [AW-1:0] alloc_a_addr, alloc_b_addr, cdb_addr;
    logic [TW-1:0] alloc_a_tag, alloc_b_tag, cdb_tag;
    logic          ckpt_save_id, ckpt_restore_id;
    logic          rd_a_busy, rd_b_busy, restore_err;
    logic [TW-1:0] rd_a_tag, rd_b_tag;
    logic [NC-1:0] ckpt_valid;
    logic [AW:0]   busy_count;

    int n_tests = 0;
    int n_fail  = 0;

    rename_alias_table #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW), .NUM_CKPT(NC)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
        .rd_a_busy(rd_a_busy), .rd_b_busy(rd_b_busy),
        .rd_a_tag(rd_a_tag), .rd_b_tag(rd_b_tag),
        .alloc_a(alloc_a), .alloc_b(alloc_b),
        .alloc_a_addr(alloc_a_addr), .alloc_b_addr(alloc_b_addr),
        .alloc_a_tag(alloc_a_tag), .alloc_b_tag(alloc_b_tag),
        .cdb_valid(cdb_valid), .cdb_addr(cdb_addr), .cdb_tag(cdb_tag),
        .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
        .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
        .ckpt_valid(ckpt_valid), .restore_err(restore_err), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: a table per register plus snapshot copies.
    bit [NR-1:0] m_busy;
    bit [TW-1:0] m_tag [NR];
    bit [NC-1:0] m_ckv;
    bit [NR-1:0] m_ck_busy [NC];
    bit [TW-1:0] m_ck_tag [NC][NR];
    bit          m_err;

    always @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            m_busy = '0;
            for (int i = 0; i < NR; i++) m_tag[i] = '0;
            m_ckv = '0;
            m_err = 1'b0;
        end else if (CK && ckpt_restore) begin
            if (m_ckv[ckpt_restore_id]) begin
                for (int k = 0; k < NC; k++)
                    if (cdb_valid && m_ck_busy[k][cdb_addr] && m_ck_tag[k][cdb_addr] == cdb_tag)
                        m_ck_busy[k][cdb_addr] = 1'b0;
                m_busy = m_ck_busy[ckpt_restore_id];
                for (int i = 0; i < NR; i++) m_tag[i] = m_ck_tag[ckpt_restore_id][i];
                m_ckv[ckpt_restore_id] = 1'b0;
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else begin
            m_err = 1'b0;
            for (int k = 0; k < NC; k++)
                if (cdb_valid && m_ck_busy[k][cdb_addr] && m_ck_tag[k][cdb_addr] == cdb_tag)
                    m_ck_busy[k][cdb_addr] = 1'b0;
            if (cdb_valid && m_busy[cdb_addr] && m_tag[cdb_addr] == cdb_tag)
                m_busy[cdb_addr] = 1'b0;
            if (alloc_a) begin m_busy[alloc_a_addr] = 1'b1; m_tag[alloc_a_addr] = alloc_a_tag; end
            if (alloc_b) begin m_busy[alloc_b_addr] = 1'b1; m_tag[alloc_b_addr] = alloc_b_tag; end
            if (CK && ckpt_save) begin
                m_ck_busy[ckpt_save_id] = m_busy;
                for (int i = 0; i < NR; i++) m_ck_tag[ckpt_save_id][i] = m_tag[i];
                m_ckv[ckpt_save_id] = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (!reset) begin
            check("m_rd_a_busy", 32'(rd_a_busy), 32'(m_busy[rd_a_addr]));
            check("m_rd_a_tag",  32'(rd_a_tag),  32'(m_tag[rd_a_addr]));
            check("m_rd_b_busy", 32'(rd_b_busy), 32'(m_busy[rd_b_addr]));
            check("m_rd_b_tag",  32'(rd_b_tag),  32'(m_tag[rd_b_addr]));
            check("m_busy_count", 32'(busy_count), 32'($countones(m_busy)));
            check("m_ckpt_valid", 32'(ckpt_valid), 32'(m_ckv));
            check("m_restore_err", 32'(restore_err), 32'(m_err));
        end
    end

    task automatic idle();
        flush = 0; alloc_a = 0; alloc_b = 0; cdb_valid = 0; ckpt_save = 0; ckpt_restore = 0;
        alloc_a_addr = '0; alloc_b_addr = '0; alloc_a_tag = '0; alloc_b_tag = '0;
        cdb_addr = '0; cdb_tag = '0; ckpt_save_id = 0; ckpt_restore_id = 0;
        rd_b_addr = rd_b_addr + 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
        idle();
    endtask

    task automatic peek(input logic [AW-1:0] a);
        rd_a_addr = a;
        #1;
    endtask

    task automatic do_alloc(input logic [AW-1:0] aa, input logic [TW-1:0] at,
                            input bit use_b, input logic [AW-1:0] ba, input logic [TW-1:0] bt);
        alloc_a = 1; alloc_a_addr = aa; alloc_a_tag = at;
        alloc_b = use_b; alloc_b_addr = ba; alloc_b_tag = bt;
    endtask

    task automatic do_cdb(input logic [AW-1:0] a, input logic [TW-1:0] t);
        cdb_valid = 1; cdb_addr = a; cdb_tag = t;
    endtask

    initial begin
        idle();
        #1 reset = 1;
        tick(); tick();
        reset = 0;
        check("reset_count", 32'(busy_count), 0);
        check("reset_ckv", 32'(ckpt_valid), 0);
        check("reset_err", 32'(restore_err), 0);

        // Alloc then read
        do_alloc(3, 5, 0, 0, 0); tick();
        peek(3);
        check("alloc_busy", 32'(rd_a_busy), 1);
        check("alloc_tag", 32'(rd_a_tag), 5);
        check("alloc_count", 32'(busy_count), 1);

        // Dual alloc to the same destination: slot b wins
        flush = 1; tick();
        do_alloc(2, 4, 1, 2, 7); tick();
        peek(2);
        check("dual_busy", 32'(rd_a_busy), 1);
        check("dual_tag", 32'(rd_a_tag), 7);
        check("dual_count", 32'(busy_count), 1);

        // CDB tag match
        flush = 1; tick();
        do_alloc(1, 6, 0, 0, 0); tick();
        do_cdb(1, 3); tick();
        peek(1);
        check("cdb_miss_busy", 32'(rd_a_busy), 1);
        do_cdb(1, 6); tick();
        peek(1);
        check("cdb_hit_busy", 32'(rd_a_busy), 0);
        do_alloc(1, 6, 0, 0, 0); tick();
        do_cdb(1, 6); do_alloc(1, 9, 0, 0, 0); tick();
        peek(1);
        check("cdb_alloc_busy", 32'(rd_a_busy), 1);
        check("cdb_alloc_tag", 32'(rd_a_tag), 9);

        // Checkpoint restore
        flush = 1; tick();
        do_alloc(4, 2, 0, 0, 0); tick();
        ckpt_save = 1; ckpt_save_id = 0; tick();
        check("save_ckv", 32'(ckpt_valid), CK ? 1 : 0);
        do_alloc(4, 8, 1, 5, 9); tick();
        do_cdb(4, 2); tick();
        ckpt_restore = 1; ckpt_restore_id = 0; tick();
        peek(4);
        check("rst_r4_busy", 32'(rd_a_busy), CK ? 0 : 1);
        check("rst_r4_tag", 32'(rd_a_tag), CK ? 2 : 8);
        peek(5);
        check("rst_r5_busy", 32'(rd_a_busy), CK ? 0 : 1);
        check("rst_ckv", 32'(ckpt_valid), 0);

        // Invalid restore
        ckpt_restore = 1; ckpt_restore_id = 1; tick();
        check("bad_rst_err", 32'(restore_err), CK ? 1 : 0);
        check("bad_rst_count", 32'(busy_count), CK ? 0 : 2);
        tick();
        check("bad_rst_err_drop", 32'(restore_err), 0);

        // Save then flush
        ckpt_save = 1; ckpt_save_id = 1; tick();
        check("save1_ckv", 32'(ckpt_valid), CK ? 2 : 0);
        flush = 1; tick();
        check("flush_ckv", 32'(ckpt_valid), 0);
        check("flush_count", 32'(busy_count), 0);

        // Back-to-back save and restore of the same slot
        do_alloc(6, 3, 0, 0, 0); ckpt_save = 1; ckpt_save_id = 1; tick();
        do_alloc(7, 1, 0, 0, 0); ckpt_restore = 1; ckpt_restore_id = 1; tick();
        peek(6);
        check("b2b_r6_busy", 32'(rd_a_busy), 1);
        check("b2b_r6_tag", 32'(rd_a_tag), 3);
        peek(7);
        check("b2b_r7_busy", 32'(rd_a_busy), CK ? 0 : 1);
        check("b2b_ckv", 32'(ckpt_valid), 0);

        // Mixed traffic checked only by the model
        for (int i = 0; i < 24; i++) begin
            do_alloc(AW'(i), TW'(i), (i % 3) != 0, AW'(i + 5), TW'(i + 2));
            if (i % 2 == 1) do_cdb(AW'(i - 1), TW'(i - 1));
            if (i % 7 == 3) begin ckpt_save = 1; ckpt_save_id = 1'(i); end
            if (i % 7 == 5) begin ckpt_restore = 1; ckpt_restore_id = 1'(i - 2); end
            tick();
        end

        // Asynchronous reset with every register busy
        flush = 1; tick();
        for (int i = 0; i < NR; i += 2) begin
            do_alloc(AW'(i), TW'(i + 1), 1, AW'(i + 1), TW'(i + 2));
            tick();
        end
        peek(7);
        check("full_count", 32'(busy_count), 8);
        reset = 1;
        #1;
        check("async_count", 32'(busy_count), 0);
        check("async_busy", 32'(rd_a_busy), 0);
        check("async_tag", 32'(rd_a_tag), 0);
        tick();
        reset = 0;
        tick();
        check("post_reset_count", 32'(busy_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
